fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one FIFO write port between NUM_REQ requesters.
- Grants one requester at a time for a burst of up to BURST_LEN words, then rotates to the next requester.
- Drives the FIFO's wr_en/data_in and stalls while the FIFO reports full.
- Sits directly in front of the team's FIFO and consumes its full, wr_ack and overflow flags.

---
 rtl/fifo_wr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NUM_REQ requesters, granting bursts of up to BURST_LEN words per turn.
// Optional per-requester write/stall statistics: define FIFO_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no grant; picks the next requester after the last owner
// BURST | owner writes one word per cycle while its req is high and FIFO not full
// STALL | owner still requesting but FIFO full; burst count held
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            accept,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          err_overflow
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_wr_cnt,
  output logic [15:0]                   stat_stall_cnt
`endif
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BURST_LEN - 1);
  localparam logic [OW-1:0] RST_OWNER = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d, rr_pick, idx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FIFO_WIDTH-1:0] data_sel;
  logic                  wr_en_q;

  assign owner = owner_q;

  // Round-robin pick: first requester after owner_q, wrapping; lowest offset wins
  always_comb begin
    rr_pick = owner_q;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = OW'((int'(owner_q) + i) % NUM_REQ);
      if (req[idx]) rr_pick = idx;
    end
  end

  // Owner's data slice, built with constant slices only
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OW'(i)) data_sel = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // State, owner and burst count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= RST_OWNER;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and write-port outputs; everything forced low under reset
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    busy         = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    accept       = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy         = 1'b1;
        fifo_wr_en   = req[owner_q] & ~fifo_full;
        fifo_data_in = data_sel;
        for (int i = 0; i < NUM_REQ; i++) begin
          accept[i] = fifo_wr_en && (owner_q == OW'(i));
        end
        if (fifo_wr_en) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (!req[owner_q]) begin
          state_d = IDLE;
        end else begin
          state_d = STALL;
        end
      end
      STALL: begin
        busy = 1'b1;
        if (!req[owner_q])  state_d = IDLE;
        else if (!fifo_full) state_d = BURST;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      busy         = 1'b0;
      fifo_wr_en   = 1'b0;
      fifo_data_in = '0;
      accept       = '0;
    end
  end

  // Sticky flag: FIFO overflowed on a write this block issued the cycle before
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      wr_en_q <= fifo_wr_en;
      if (fifo_overflow && wr_en_q) err_overflow <= 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [OW-1:0] ack_owner_q;

  // Saturating ack counters per write owner, plus STALL cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_owner_q    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (fifo_wr_en) ack_owner_q <= owner_q;
      if (fifo_wr_ack) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ack_owner_q == OW'(i) && stat_wr_cnt[i*16 +: 16] != 16'hFFFF)
            stat_wr_cnt[i*16 +: 16] <= stat_wr_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if (state_q == STALL && stat_stall_cnt != 16'hFFFF)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = fifo_wr_ack;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester models drive data and a
// depth-8 FIFO model supplies full/ack/overflow; a monitor checks every write.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   accept;
  logic [1:0]     owner;
  logic           busy, fifo_wr_en, err_overflow;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_full;
  logic           fifo_wr_ack = 1'b0;
  logic           fifo_overflow = 1'b0;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_wr_cnt;
  logic [15:0]     stat_stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .accept(accept),
    .owner(owner), .busy(busy), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .err_overflow(err_overflow)
`ifdef FIFO_ARB_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester models: each holds req while words remain, data = base + index
  int unsigned  ptr[N]   = '{default: 0};
  int unsigned  lim[N]   = '{default: 0};
  int unsigned  start[N] = '{default: 0};
  logic [W-1:0] base[N]  = '{default: '0};

  always @(posedge clk)
    for (int i = 0; i < N; i++) if (accept[i]) ptr[i] <= ptr[i] + 1;

  always_comb begin
    req = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = ptr[i] < lim[i];
      req_data[i*W +: W] = base[i] + W'(ptr[i] - start[i]);
    end
  end

  task automatic load(int r, int n, logic [W-1:0] b);
    start[r] = ptr[r];
    lim[r]   = ptr[r] + n;
    base[r]  = b;
  endtask

  // FIFO model: no reads unless rd pulses or drain is set
  int   fcount = 0;
  logic rd = 1'b0, drain = 1'b1;
  assign fifo_full = (fcount == DEPTH);

  always @(posedge clk) begin
    fcount        <= fcount + (fifo_wr_en ? 1 : 0) - (((rd || drain) && fcount > 0) ? 1 : 0);
    fifo_wr_ack   <= fifo_wr_en;
    fifo_overflow <= fifo_wr_en && (fcount == DEPTH);
  end

  // Scoreboard of expected writes; gap = idle cycles before this write (-1 = any)
  typedef struct {
    logic [N-1:0] acc;
    logic [W-1:0] data;
    int           gap;
  } exp_t;
  exp_t sb[$];

  task automatic push_run(int r, logic [W-1:0] b, int n, int first_gap);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.acc  = N'(1 << r);
      e.data = b + W'(k);
      e.gap  = (k == 0) ? first_gap : 0;
      sb.push_back(e);
    end
  endtask

  int idle_run = 0;

  // Monitor: compares each presented write against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (fifo_wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: data %0h accept %b, expected no write", fifo_data_in, accept);
      end else begin
        e = sb.pop_front();
        chk("accept", 32'(accept), 32'(e.acc));
        chk("data", 32'(fifo_data_in), 32'(e.data));
        if (e.gap >= 0) chk("gap", 32'(idle_run), 32'(e.gap));
      end
      chk("wr_while_full", 32'(fifo_full), 32'd0);
      chk("err_overflow", 32'(err_overflow), 32'd0);
      idle_run = 0;
    end else begin
      chk("accept_idle", 32'(accept), 32'd0);
      idle_run++;
    end
  end

  task automatic wait_done(string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d writes pending, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_stall(string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = busy && fifo_full && !fifo_wr_en;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: stall not seen, got none in 200 cycles, expected one", name);
    end
  endtask

  initial begin
    // Reset with all requesters already pending; then rotation 0,1,2,3,0
    push_run(0, 16'h1000, 4, -1);
    push_run(1, 16'h2000, 4, 1);
    push_run(2, 16'h3000, 4, 1);
    push_run(3, 16'h4000, 4, 1);
    push_run(0, 16'h1004, 4, 1);
    load(0, 8, 16'h1000);
    load(1, 4, 16'h2000);
    load(2, 4, 16'h3000);
    load(3, 4, 16'h4000);
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_data", 32'(fifo_data_in), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_owner", 32'(owner), 32'd3);
    chk("arb_cycle_wr_en", 32'(fifo_wr_en), 32'd0);
    @(negedge clk);
    chk("first_write_latency", 32'(fifo_wr_en), 32'd1);
    wait_done("rotation");

    // Single requester 2: bursts 4,4,2 separated by one idle cycle
    push_run(2, 16'hA000, 4, -1);
    push_run(2, 16'hA004, 4, 1);
    push_run(2, 16'hA008, 2, 1);
    load(2, 10, 16'hA000);
    wait_done("single");

    // Full stall: 8 writes fill the FIFO, one read frees one slot, then drain
    drain = 1'b0;
    push_run(1, 16'hB000, 4, -1);
    push_run(1, 16'hB004, 4, 1);
    push_run(1, 16'hB008, 1, -1);
    push_run(1, 16'hB009, 3, -1);
    push_run(1, 16'hB00C, 1, 1);
    load(1, 13, 16'hB000);
    wait_stall("stall_first");
    repeat (3) @(negedge clk);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("stall_fill", 32'(fcount), 32'd8);
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    wait_stall("stall_second");
    repeat (2) @(negedge clk);
    chk("stall2_wr_en", 32'(fifo_wr_en), 32'd0);
    @(posedge clk); #1 drain = 1'b1;
    wait_done("stall");

    // Early release: requester 3 gives up after 2 words, 0 is next
    push_run(3, 16'h5000, 2, -1);
    push_run(0, 16'h6000, 2, 2);
    load(3, 2, 16'h5000);
    load(0, 2, 16'h6000);
    wait_done("early_release");

    // Reset during owner 1's second word
    push_run(1, 16'hC000, 1, -1);
    push_run(0, 16'hD000, 2, -1);
    push_run(1, 16'hC001, 3, 2);
    load(1, 4, 16'hC000);
    load(0, 2, 16'hD000);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_accept", 32'(accept), 32'd0);
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_owner", 32'(owner), 32'd3);
    wait_done("midrst");

    // Statistics: fresh reset, 12 words from 0 and 4 from 2 with one stall
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef FIFO_ARB_STATS_EN
    chk("stat_stall_rst", 32'(stat_stall_cnt), 32'd0);
`endif
    drain = 1'b0;
    push_run(0, 16'hE000, 4, -1);
    push_run(2, 16'hF000, 4, 1);
    push_run(0, 16'hE004, 4, -1);
    push_run(0, 16'hE008, 4, 1);
    load(0, 12, 16'hE000);
    load(2, 4, 16'hF000);
    wait_stall("stats_stall");
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 drain = 1'b1;
    wait_done("stats");
    repeat (2) @(posedge clk);
    #1;
`ifdef FIFO_ARB_STATS_EN
    chk("stat_wr0", 32'(stat_wr_cnt[0*16 +: 16]), 32'd12);
    chk("stat_wr1", 32'(stat_wr_cnt[1*16 +: 16]), 32'd0);
    chk("stat_wr2", 32'(stat_wr_cnt[2*16 +: 16]), 32'd4);
    chk("stat_wr3", 32'(stat_wr_cnt[3*16 +: 16]), 32'd0);
    chk("stat_stall", 32'(stat_stall_cnt), 32'd5);
`endif
    chk("final_err_overflow", 32'(err_overflow), 32'd0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
